// File: rtl/dma_hostrd_burst_gen_if.sv
// Command-queue and AVMM host-read signals of the host-read burst generator.
// The master modport is the generator's own view; slave is the view of the
// command queue and host memory side.
interface dma_hostrd_burst_gen_if #(
  parameter int unsigned ADDR_W  = 48,
  parameter int unsigned XFER_W  = 40,
  parameter int unsigned BURST_W = 7
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src_addr;
  logic [XFER_W-1:0] cmd_len;

  logic [ADDR_W-1:0]  avmm_address;
  logic               avmm_read;
  logic [BURST_W-1:0] avmm_burstcount;
  logic               avmm_waitrequest;
  logic               avmm_readdatavalid;

  modport master (
    input  cmd_valid, cmd_src_addr, cmd_len,
    output cmd_ready,
    output avmm_address, avmm_read, avmm_burstcount,
    input  avmm_waitrequest, avmm_readdatavalid
  );

  modport slave (
    output cmd_valid, cmd_src_addr, cmd_len,
    input  cmd_ready,
    input  avmm_address, avmm_read, avmm_burstcount,
    output avmm_waitrequest, avmm_readdatavalid
  );
endinterface

// File: rtl/dma_hostrd_burst_gen.sv
// Host-to-FPGA DMA read-request generator: pops one (address, length) command,
// issues credit-throttled AVMM read bursts that never cross a BURST_MAX-word
// boundary, and signals completion once every requested word has returned.
module dma_hostrd_burst_gen #(
  parameter int unsigned ADDR_W    = 48,
  parameter int unsigned XFER_W    = 40,
  parameter int unsigned BURST_W   = 7,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned BUF_DEPTH = 1024,
  parameter int unsigned CNT_W     = 32,
  localparam int unsigned USEDW_W  = $clog2(BUF_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclr,
  dma_hostrd_burst_gen_if.master bus,
  input  logic [USEDW_W-1:0]  buf_usedw,
  output logic                busy,
  output logic                xfer_done,
  output logic [CNT_W-1:0]    burst_cnt,
  output logic [CNT_W-1:0]    rddv_cnt
);

  localparam int unsigned REM_W  = XFER_W - 6;
  localparam int unsigned OUT_W  = USEDW_W;
  localparam int unsigned LOG2BM = $clog2(BURST_MAX);
  localparam int unsigned LSB_W  = (LOG2BM == 0) ? 1 : LOG2BM;
  localparam int unsigned CR_W   = OUT_W + BURST_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               clear;
  logic [ADDR_W-1:0]  addr_q;
  logic [REM_W-1:0]   rem_q;
  logic [OUT_W-1:0]   outst_q, outst_d;
  logic [OUT_W:0]     outst_sum;
  logic               read_q;
  logic [BURST_W-1:0] bc_q, bc_next, space;
  logic [LSB_W-1:0]   word_lsb;
  logic               credit_ok;
  logic               pop, issue, accept, done_d, done_q;
  logic [REM_W-1:0]   cmd_words;
  logic               unused_low_bits;

  assign clear     = reset | sclr;
  assign cmd_words = bus.cmd_len[XFER_W-1:6];
  // Sub-word address/length bits carry no meaning.
  assign unused_low_bits = ^{bus.cmd_src_addr[5:0], bus.cmd_len[5:0]};

  assign bus.cmd_ready       = pop;
  assign bus.avmm_address    = addr_q;
  assign bus.avmm_read       = read_q;
  assign bus.avmm_burstcount = bc_q;
  assign busy                = (state_q != IDLE);
  assign xfer_done           = done_q;

  // Size of the next burst and whether the read-data buffer has room for it.
  always_comb begin
    word_lsb = addr_q[6 +: LSB_W] & LSB_W'(BURST_MAX - 1);
    space    = BURST_W'(BURST_MAX) - BURST_W'(word_lsb);
    if (rem_q < REM_W'(space)) bc_next = BURST_W'(rem_q);
    else                       bc_next = space;
    credit_ok = (CR_W'(buf_usedw) + CR_W'(outst_q) + CR_W'(bc_next)) <= CR_W'(BUF_DEPTH);
  end

  // Outstanding words: add an accepted burst, retire a returned word, never below zero.
  always_comb begin
    outst_sum = {1'b0, outst_q} + (accept ? (OUT_W+1)'(bc_q) : '0);
    if (bus.avmm_readdatavalid && (outst_sum != '0))
      outst_sum = outst_sum - (OUT_W+1)'(1);
    outst_d = outst_sum[OUT_W-1:0];
  end

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    issue   = 1'b0;
    accept  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && !clear) begin
          pop = 1'b1;
          if (cmd_words == '0) done_d  = 1'b1;
          else                 state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (read_q) begin
          if (!bus.avmm_waitrequest) begin
            accept = 1'b1;
            if (rem_q == REM_W'(bc_q)) state_d = DRAIN;
          end
        end else if ((rem_q != '0) && credit_ok) begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        // Completion is judged on the post-edge count so the pulse lands the
        // cycle after the last word, together with busy falling.
        if (outst_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Command registers, request outputs, outstanding count and status counters.
  always_ff @(posedge clk) begin
    if (clear) begin
      addr_q    <= '0;
      rem_q     <= '0;
      outst_q   <= '0;
      read_q    <= 1'b0;
      bc_q      <= '0;
      done_q    <= 1'b0;
      burst_cnt <= '0;
      rddv_cnt  <= '0;
    end else begin
      outst_q <= outst_d;
      done_q  <= done_d;
      if (pop) begin
        addr_q <= {bus.cmd_src_addr[ADDR_W-1:6], 6'b0};
        rem_q  <= cmd_words;
      end
      if (issue) begin
        read_q <= 1'b1;
        bc_q   <= bc_next;
      end
      if (accept) begin
        read_q    <= 1'b0;
        addr_q    <= addr_q + (ADDR_W'(bc_q) << 6);
        rem_q     <= rem_q - REM_W'(bc_q);
        burst_cnt <= burst_cnt + CNT_W'(bc_q);
      end
      if (bus.avmm_readdatavalid) rddv_cnt <= rddv_cnt + CNT_W'(1);
    end
  end

endmodule
